mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Sequences the CPU's byte-wide memory bus (mem_a/mem_dout/mem_wr/mem_din) and shares it between
//  instruction fetch (IF, 32-bit word reads) and the load/store unit (LS, byte/half/word reads and writes).
//  It serialises each access into byte cycles, reassembles read data little-endian and honours rdy_in.
//  It also throttles I/O writes while io_buffer_full is high. Sits inside cpu, between IF/LS and the top-level bus.
// PARAMETERS
//  IO_HI     2'b11  value of addr[17:16] that selects the I/O region (0x30000+)
//  ADDR_W    32     bus address width
// PORTS
//  clk_in          in   1   system clock
//  rst_n_in        in   1   asynchronous active-low reset
//  rdy_in          in   1   0 = bus owned by debug interface; freeze
//  mem_din         in   8   read byte; valid the cycle after the RAM samples mem_a
//  mem_dout        out  8   write byte
//  mem_a           out  32  byte address
//  mem_wr          out  1   1 = write this cycle
//  io_buffer_full  in   1   I/O sink cannot accept a write
//  if_req          in   1   IF word-read request; held with if_addr until if_done
//  if_addr         in   32  IF byte address
//  if_done         out  1   one-cycle pulse; if_data valid in that cycle
//  if_data         out  32  fetched word
//  flush_in        in   1   abort any IF transaction
//  ls_req          in   1   LS request; held with operands until ls_done
//  ls_wr           in   1   1 = store
//  ls_size         in   2   0 byte, 1 half, 2 word (N = 1,2,4)
//  ls_addr         in   32  byte address; no alignment required
//  ls_wdata        in   32  store data; byte i = ls_wdata[8i+7:8i]
//  ls_done         out  1   one-cycle pulse; ls_rdata valid for loads
//  ls_rdata        out  32  load data, zero-extended (LS sign-extends)
// BEHAVIOUR
//  - Reset (async, rst_n_in=0): state IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0,
//    if_data=0, ls_rdata=0, last_grant=IF. All outputs registered.
//  - FSM: IDLE, READ, WRITE. Counters: issue count (0..N) and capture count (0..N). Byte addresses are
//    addr+i, modulo 2^32.
//  - Arbitration in IDLE (rdy_in=1): LS wins unless last_grant=LS and if_req=1. An IF request with
//    flush_in=1 is ignored. Grant edge E0 latches the operands and updates last_grant.
//  - READ: mem_a <= addr+i at edges E0..E(N-1), mem_wr=0. Byte i is captured from mem_din at E(i+2).
//    done pulses in the cycle after E(N+1): word 5 cycles, byte 2 cycles. Then IDLE, with mem_a <= 0.
//  - WRITE: mem_a, mem_dout and mem_wr=1 are driven for byte i at successive edges starting E0.
//    ls_done is high in the same cycle as the last byte. At the next edge go to IDLE with mem_wr <= 0.
//  - I/O write (addr[17:16]==IO_HI) with io_buffer_full=1: do not issue the byte (mem_wr=0) and hold the
//    byte index; issue on the first edge where full=0. Check this per byte.
//  - Requesters drop req in the done cycle. IDLE re-arbitrates the cycle after done (one bubble).
//  - flush_in=1 during an IF READ: next edge goes to IDLE, mem_a<=0, no if_done. LS transactions ignore flush.
//  - rdy_in=0: all state and outputs are frozen, except mem_wr, which is forced to 0.
//    On resume, a READ restarts from byte 0 (in-flight captures are discarded).
//    A WRITE resumes at the current byte.
//  - Idle mem_a is 0, so idle cycles never touch I/O.
// STRUCTURE
//  - Shared package mem_arb_pkg: state encoding, size codes SZ_B/SZ_H/SZ_W, IO_HI, GRANT_IF/GRANT_LS.
//  - Single FSM module; no sub-module is needed. Byte-lane packing is inline.
// TESTING
//  1. IF read 0x1000, RAM = 11,22,33,44 -> mem_a 0x1000..0x1003; if_done 5 cycles after grant;
//     if_data=0x44332211; mem_wr stays 0.
//  2. SW 0xDEADBEEF @0x2002 -> mem_a 0x2002..0x2005, mem_dout EF,BE,AD,DE, mem_wr=1 for 4 cycles,
//     ls_done with the last byte.
//  3. if_req and ls_req both high from reset -> LS then IF. Both again -> LS. Then with last_grant=LS
//     and both pending -> IF.
//  4. SB 0x41 @0x30000 with io_buffer_full high 3 cycles -> mem_wr=0 throughout; single write the cycle
//     after full drops.
//  5. flush_in during IF byte 2 with LB pending -> no if_done; mem_a=0; LB granted next and
//     ls_rdata=0x000000xx.
//  6. rdy_in low 4 cycles mid word-load -> mem_wr=0; read restarts at byte 0 and returns correct data.
//     Then rst_n_in low mid-store -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the byte-serial memory bus arbiter.
package mem_arb_pkg;

    // Bus sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Owner of the current (or most recent) grant
    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_LS = 1'b1
    } grant_t;

    // Load/store size codes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // addr[17:16] value that selects the I/O region
    localparam logic [1:0] IO_HI = 2'b11;

    // Number of byte cycles for a size code; unused code 3 is treated as a word
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Little-endian byte lane i of a 32-bit word
    function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial memory bus sequencer shared by instruction fetch and load/store.
// Reads are pipelined: byte i is issued at grant edge E(i) and captured two
// edges later; writes put one byte per cycle on the bus and pause on a full
// I/O buffer. rdy_in low freezes everything (writes are suppressed).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [1:0] IO_HI  = mem_arb_pkg::IO_HI,
    parameter int         ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              flush_in,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata
);

    state_t            state_reg;
    grant_t            grant_reg;
    grant_t            last_grant_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [2:0]        nbytes_reg;
    logic [2:0]        issue_reg;   // bytes put on the bus so far
    logic [2:0]        cap_reg;     // bytes captured so far
    logic [1:0]        pipe_reg;    // [0]: issued last edge, [1]: issued two edges ago
    logic [31:0]       rbuf_reg;

    // Address / data of the byte about to be issued
    logic [ADDR_W-1:0] issue_addr;
    logic [7:0]        issue_byte;
    logic              io_blocked;

    assign issue_addr = addr_reg + {{(ADDR_W-3){1'b0}}, issue_reg};
    assign issue_byte = byte_lane(wdata_reg, issue_reg[1:0]);
    assign io_blocked = (issue_addr[17:16] == IO_HI) && io_buffer_full;

    // Arbitration: LS wins unless it had the last grant and IF is waiting
    logic              if_eff;
    logic              pick_ls;
    logic              pick_if;
    logic [ADDR_W-1:0] g_addr;
    logic [2:0]        g_n;
    logic              g_write;
    logic              g_io_block;

    assign if_eff     = if_req && !flush_in;
    assign pick_ls    = ls_req && !((last_grant_reg == GRANT_LS) && if_eff);
    assign pick_if    = !pick_ls && if_eff;
    assign g_addr     = pick_ls ? ls_addr : if_addr;
    assign g_n        = pick_ls ? size_bytes(ls_size) : 3'd4;
    assign g_write    = pick_ls && ls_wr;
    assign g_io_block = (ls_addr[17:16] == IO_HI) && io_buffer_full;

    // Read buffer with the incoming byte merged into its little-endian lane
    logic [31:0] rbuf_next;

    // Merge mem_din into the lane selected by the capture count
    always_comb begin
        rbuf_next = rbuf_reg;
        rbuf_next[{cap_reg[1:0], 3'b000} +: 8] = mem_din;
    end

    // Bus sequencer FSM with all outputs registered
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= GRANT_IF;
            last_grant_reg <= GRANT_IF;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            nbytes_reg     <= '0;
            issue_reg      <= '0;
            cap_reg        <= '0;
            pipe_reg       <= '0;
            rbuf_reg       <= '0;
            mem_a          <= '0;
            mem_dout       <= '0;
            mem_wr         <= 1'b0;
            if_done        <= 1'b0;
            if_data        <= '0;
            ls_done        <= 1'b0;
            ls_rdata       <= '0;
        end else if (!rdy_in) begin
            // Debug owns the bus: hold everything, never write. A read in
            // progress is rewound so it restarts cleanly from byte 0.
            mem_wr <= 1'b0;
            if (state_reg == ST_READ) begin
                issue_reg <= '0;
                cap_reg   <= '0;
                pipe_reg  <= '0;
                rbuf_reg  <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    mem_a   <= '0;
                    mem_wr  <= 1'b0;
                    if_done <= 1'b0;
                    ls_done <= 1'b0;
                    // A done still showing means the requester has not yet
                    // dropped its request: wait one bubble before granting.
                    if (!if_done && !ls_done && (pick_ls || pick_if)) begin
                        grant_reg      <= pick_ls ? GRANT_LS : GRANT_IF;
                        last_grant_reg <= pick_ls ? GRANT_LS : GRANT_IF;
                        addr_reg       <= g_addr;
                        wdata_reg      <= ls_wdata;
                        nbytes_reg     <= g_n;
                        cap_reg        <= '0;
                        rbuf_reg       <= '0;
                        mem_a          <= g_addr;
                        if (g_write) begin
                            state_reg <= ST_WRITE;
                            mem_dout  <= ls_wdata[7:0];
                            pipe_reg  <= '0;
                            if (g_io_block) begin
                                issue_reg <= '0;
                            end else begin
                                mem_wr    <= 1'b1;
                                issue_reg <= 3'd1;
                                ls_done   <= (g_n == 3'd1);
                            end
                        end else begin
                            state_reg <= ST_READ;
                            issue_reg <= 3'd1;
                            pipe_reg  <= 2'b01;
                        end
                    end
                end

                ST_READ: begin
                    if (flush_in && (grant_reg == GRANT_IF)) begin
                        state_reg <= ST_IDLE;
                        mem_a     <= '0;
                        issue_reg <= '0;
                        cap_reg   <= '0;
                        pipe_reg  <= '0;
                    end else begin
                        pipe_reg <= {pipe_reg[0], (issue_reg < nbytes_reg)};
                        if (issue_reg < nbytes_reg) begin
                            mem_a     <= issue_addr;
                            issue_reg <= issue_reg + 3'd1;
                        end else begin
                            mem_a <= '0;
                        end
                        if (pipe_reg[1]) begin
                            rbuf_reg <= rbuf_next;
                            cap_reg  <= cap_reg + 3'd1;
                            if (cap_reg == nbytes_reg - 3'd1) begin
                                state_reg <= ST_IDLE;
                                mem_a     <= '0;
                                issue_reg <= '0;
                                cap_reg   <= '0;
                                pipe_reg  <= '0;
                                if (grant_reg == GRANT_IF) begin
                                    if_done <= 1'b1;
                                    if_data <= rbuf_next;
                                end else begin
                                    ls_done  <= 1'b1;
                                    ls_rdata <= rbuf_next;
                                end
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (issue_reg == nbytes_reg) begin
                        state_reg <= ST_IDLE;
                        mem_wr    <= 1'b0;
                        ls_done   <= 1'b0;
                        mem_a     <= '0;
                        issue_reg <= '0;
                    end else begin
                        mem_a    <= issue_addr;
                        mem_dout <= issue_byte;
                        if (io_blocked) begin
                            mem_wr  <= 1'b0;
                            ls_done <= 1'b0;
                        end else begin
                            mem_wr    <= 1'b1;
                            issue_reg <= issue_reg + 3'd1;
                            ls_done   <= (issue_reg == nbytes_reg - 3'd1);
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    mem_a     <= '0;
                    mem_wr    <= 1'b0;
                end
            endcase
        end
    end

endmodule
